// File: rtl/compliance_sig_monitor_pkg.sv
// -----------------------------------------------------------------------------
// compliance_sig_monitor_pkg
//   Shared constants and types for the compliance signature monitor.
//   - Default mailbox byte addresses written by the test program.
//   - Default limits for signature length and the end-of-test timeout.
//   - FSM state type used by the top level.
// -----------------------------------------------------------------------------
package compliance_sig_monitor_pkg;

    // Mailbox words the test program writes at the end of a run.
    localparam logic [31:0] SIG_BEGIN_ADDR_DEF = 32'h1000_0008;
    localparam logic [31:0] SIG_END_ADDR_DEF   = 32'h1000_000C;
    localparam logic [31:0] END_FLAG_ADDR_DEF  = 32'h1000_0010;

    // Largest signature accepted, in words, and cycles allowed before the
    // end flag must arrive (0 disables the timeout).
    localparam int MAX_SIG_WORDS_DEF  = 1024;
    localparam int TIMEOUT_CYCLES_DEF = 25000;

    // Monitor state machine. FINISH, ERROR and TIMEOUT are absorbing.
    typedef enum logic [2:0] {
        ST_ARMED   = 3'd0,  // snooping mailbox writes, timeout running
        ST_CHECK   = 3'd1,  // one-cycle validation of the captured range
        ST_RD_REQ  = 3'd2,  // issue read of the current signature word
        ST_RD_WAIT = 3'd3,  // read data returns this cycle
        ST_OUT     = 3'd4,  // word presented on the stream until accepted
        ST_FINISH  = 3'd5,  // dump complete
        ST_ERROR   = 3'd6,  // illegal signature range
        ST_TIMEOUT = 3'd7   // end flag never arrived
    } state_t;

endpackage : compliance_sig_monitor_pkg

// File: rtl/compliance_sig_monitor_sim_timeout_cnt.sv
// -----------------------------------------------------------------------------
// sim_timeout_cnt
//   Free-running cycle counter with a single-cycle terminal-count indication.
//   The terminal count is asserted combinationally in the cycle where the
//   counter holds TIMEOUT_CYCLES-1 while enabled, so the consumer can act on
//   the same clock edge that would have been the TIMEOUT_CYCLES-th count.
//   TIMEOUT_CYCLES = 0 disables the terminal count entirely.
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   en    in   count enable
//   clr   in   synchronous clear (has priority over en)
//   tc    out  terminal-count pulse
// -----------------------------------------------------------------------------
module sim_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    // Only values 0..TIMEOUT_CYCLES-1 are ever held.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic ENABLED = (TIMEOUT_CYCLES > 0);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = ENABLED && en && at_last;

endmodule : sim_timeout_cnt

// File: rtl/compliance_sig_monitor.sv
// -----------------------------------------------------------------------------
// compliance_sig_monitor
//   End-of-test signature dumper. Snoops RAM writes for the signature-begin,
//   signature-end and end-flag mailbox words. When the end flag (data == 1)
//   is written, the captured range is validated and each signature word is
//   read over a dedicated memory read port and streamed out on a
//   valid/ready interface. A timeout fires if the end flag never arrives.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   mon_we_i     in   snooped RAM write strobe
//   mon_addr_i   in   snooped write byte address
//   mon_data_i   in   snooped write data
//   mem_rd_o     out  one-cycle read request
//   mem_addr_o   out  word-aligned read byte address
//   mem_rdata_i  in   read data, valid one cycle after mem_rd_o
//   sig_valid_o  out  signature word valid
//   sig_data_o   out  signature word
//   sig_last_o   out  final word of the signature (with sig_valid_o)
//   sig_ready_i  in   sink accepts the word when valid & ready
//   busy_o       out  dump in progress
//   done_o       out  sticky: dump finished, range error or timeout
//   timeout_o    out  sticky: end flag never arrived
//   err_o        out  sticky: illegal signature range
// -----------------------------------------------------------------------------
module compliance_sig_monitor
    import compliance_sig_monitor_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] SIG_BEGIN_ADDR = ADDR_W'(SIG_BEGIN_ADDR_DEF),
    parameter logic [ADDR_W-1:0] SIG_END_ADDR   = ADDR_W'(SIG_END_ADDR_DEF),
    parameter logic [ADDR_W-1:0] END_FLAG_ADDR  = ADDR_W'(END_FLAG_ADDR_DEF),
    parameter int                MAX_SIG_WORDS  = MAX_SIG_WORDS_DEF,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_we_i,
    input  logic [ADDR_W-1:0] mon_addr_i,
    input  logic [DATA_W-1:0] mon_data_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              sig_valid_o,
    output logic [DATA_W-1:0] sig_data_o,
    output logic              sig_last_o,
    input  logic              sig_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              err_o
);

    // Word index and length must represent MAX_SIG_WORDS itself.
    localparam int LEN_W = $clog2(MAX_SIG_WORDS + 1);

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] sig_begin;
    logic [ADDR_W-1:0] sig_end;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] data_q;

    logic              armed;
    logic              hit_begin;
    logic              hit_end;
    logic              flag_go;
    logic              tmo_tc;

    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] span_words;
    logic              range_bad;
    logic              range_empty;
    logic              is_last;
    logic              accept;
    logic [ADDR_W-1:0] rd_addr;

    // -------------------------------------------------------------------------
    // Mailbox decode. Full-width address compare; only honoured while ARMED.
    // -------------------------------------------------------------------------
    assign armed     = (state == ST_ARMED);
    assign hit_begin = armed && mon_we_i && (mon_addr_i == SIG_BEGIN_ADDR);
    assign hit_end   = armed && mon_we_i && (mon_addr_i == SIG_END_ADDR);
    assign flag_go   = armed && mon_we_i && (mon_addr_i == END_FLAG_ADDR)
                       && (mon_data_i == DATA_W'(1));

    // -------------------------------------------------------------------------
    // Timeout: counts only while ARMED, cleared as soon as the FSM leaves.
    // -------------------------------------------------------------------------
    sim_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .en  (armed),
        .clr (!armed),
        .tc  (tmo_tc)
    );

    // -------------------------------------------------------------------------
    // Range validation. The subtraction can wrap when begin > end, but that
    // case is already flagged by the ordering test, so the wrapped length is
    // never used.
    // -------------------------------------------------------------------------
    assign span        = sig_end - sig_begin;
    assign span_words  = span >> 2;
    assign range_empty = (sig_begin == sig_end);
    assign range_bad   = (sig_begin[1:0] != 2'b00)
                       || (sig_end[1:0] != 2'b00)
                       || (sig_begin > sig_end)
                       || (span_words > ADDR_W'(MAX_SIG_WORDS));

    assign is_last = (idx == (len - LEN_W'(1)));
    assign accept  = (state == ST_OUT) && sig_ready_i;
    assign rd_addr = sig_begin + (ADDR_W'(idx) << 2);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic. The end flag is tested before the timeout so a
    // flag write in the cycle the timeout fires still starts the dump.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARMED: begin
                if (flag_go) begin
                    state_nxt = ST_CHECK;
                end else if (tmo_tc) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (range_bad) begin
                    state_nxt = ST_ERROR;
                end else if (range_empty) begin
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_OUT;
            ST_OUT: begin
                if (sig_ready_i) begin
                    state_nxt = is_last ? ST_FINISH : ST_RD_REQ;
                end
            end
            default: state_nxt = state;  // FINISH / ERROR / TIMEOUT absorb
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: mailbox capture, length/index, read-data holding register.
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are reset too (not just the FSM) because
    // mem_addr_o and sig_data_o must read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_begin <= '0;
            sig_end   <= '0;
            len       <= '0;
            idx       <= '0;
            data_q    <= '0;
        end else begin
            if (hit_begin) begin
                sig_begin <= mon_addr_i == SIG_BEGIN_ADDR ? ADDR_W'(mon_data_i) : sig_begin;
            end
            if (hit_end) begin
                sig_end <= ADDR_W'(mon_data_i);
            end
            if (state == ST_CHECK) begin
                len <= span_words[LEN_W-1:0];
                idx <= '0;
            end
            if (state == ST_RD_WAIT) begin
                data_q <= mem_rdata_i;
            end
            if (accept) begin
                idx <= idx + LEN_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM outputs, decoded from state only (apart from the read address and
    // last flag, which also depend on the index).
    // -------------------------------------------------------------------------
    always_comb begin
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;
        sig_valid_o = 1'b0;
        sig_last_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        timeout_o   = 1'b0;
        err_o       = 1'b0;
        case (state)
            ST_RD_REQ: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = rd_addr;
                busy_o     = 1'b1;
            end
            ST_RD_WAIT: begin
                busy_o = 1'b1;
            end
            ST_OUT: begin
                sig_valid_o = 1'b1;
                sig_last_o  = is_last;
                busy_o      = 1'b1;
            end
            ST_FINISH: begin
                done_o = 1'b1;
            end
            ST_ERROR: begin
                done_o = 1'b1;
                err_o  = 1'b1;
            end
            ST_TIMEOUT: begin
                done_o    = 1'b1;
                timeout_o = 1'b1;
            end
            default: begin
                mem_rd_o = 1'b0;
            end
        endcase
    end

    // Held stable through OUT because it only loads in RD_WAIT.
    assign sig_data_o = data_q;

endmodule : compliance_sig_monitor

// File: tb/tb_compliance_sig_monitor.sv
// -----------------------------------------------------------------------------
// tb_compliance_sig_monitor
//   Self-checking bench for compliance_sig_monitor. Expected signature words
//   are pushed to a scoreboard queue when a dump is started and popped as the
//   DUT streams them out. A simple memory model returns a word derived from
//   the read address one cycle after each read request.
// -----------------------------------------------------------------------------
module tb_compliance_sig_monitor;

    localparam logic [31:0] A_BEGIN = 32'h1000_0008;
    localparam logic [31:0] A_END   = 32'h1000_000C;
    localparam logic [31:0] A_FLAG  = 32'h1000_0010;
    localparam int          TMO     = 50;
    localparam int          STALL   = 5;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mon_we_i;
    logic [31:0] mon_addr_i;
    logic [31:0] mon_data_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        sig_last_o;
    logic        sig_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic        err_o;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   words_seen;
    int   reads_seen;
    int   stall_reads;
    int   stall_cycles;
    int   stall_cnt;
    bit   hs_flag;
    bit   bp_mode;

    compliance_sig_monitor #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mon_we_i    (mon_we_i),
        .mon_addr_i  (mon_addr_i),
        .mon_data_i  (mon_data_i),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .sig_valid_o (sig_valid_o),
        .sig_data_o  (sig_data_o),
        .sig_last_o  (sig_last_o),
        .sig_ready_i (sig_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 0xA0 at 0x1000_0100, incrementing per word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA0 + ((addr - 32'h1000_0100) >> 2);
    endfunction

    // Read data valid exactly one cycle after the request, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata_i <= mem_rd_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitor / scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_rd_o) reads_seen++;
                if (mem_rd_o && sig_valid_o && !sig_ready_i) stall_reads++;
                if (sig_valid_o && !sig_ready_i) stall_cycles++;
                if (sig_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        check("sig_data", 64'(sig_data_o), 64'(exp_q[0].data));
                        check("sig_last", 64'(sig_last_o), 64'(exp_q[0].last));
                        if (sig_ready_i) begin
                            void'(exp_q.pop_front());
                            words_seen++;
                            hs_flag = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Sink ready: always high, or held low STALL cycles per word in bp_mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs_flag) begin
                stall_cnt = 0;
                hs_flag   = 1'b0;
            end
            if (bp_mode && sig_valid_o && stall_cnt < STALL) begin
                sig_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                sig_ready_i = 1'b1;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr_data"}, {mem_addr_o, sig_data_o}, 64'd0);
        check({tag, "_flags"},
              64'({mem_rd_o, sig_valid_o, sig_last_o, busy_o, done_o, timeout_o, err_o}),
              64'd0);
    endtask

    // Leaves the bench at posedge+1 with reset just released.
    task automatic do_reset();
        rst        = 1'b0;
        mon_we_i   = 1'b0;
        mon_addr_i = '0;
        mon_data_i = '0;
        bp_mode    = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        words_seen   = 0;
        reads_seen   = 0;
        stall_reads  = 0;
        stall_cycles = 0;
        stall_cnt    = 0;
        hs_flag      = 1'b0;
        check_outputs_zero("reset");
        rst = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mon_we_i   = 1'b1;
        mon_addr_i = addr;
        mon_data_i = data;
        @(posedge clk);
        #1;
        mon_we_i = 1'b0;
    endtask

    task automatic push_dump(input logic [31:0] b, input logic [31:0] e);
        int n;
        n = int'((e - b) >> 2);
        for (int i = 0; i < n; i++) begin
            exp_t w;
            w.data = mem_word(b + 32'(4 * i));
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_dump(input logic [31:0] b, input logic [31:0] e);
        bus_write(A_BEGIN, b);
        bus_write(A_END, e);
        bus_write(A_FLAG, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done_o && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 64'(done_o), 64'd1);
    endtask

    task automatic expect_end(input string tag, input int budget, input int words,
                              input logic err, input logic tmo);
        wait_done(tag, budget);
        check({tag, "_err"},     64'(err_o), 64'(err));
        check({tag, "_timeout"}, 64'(timeout_o), 64'(tmo));
        check({tag, "_busy"},    64'(busy_o), 64'd0);
        check({tag, "_words"},   64'(words_seen), 64'(words));
        check({tag, "_reads"},   64'(reads_seen), 64'(words));
        check({tag, "_left"},    64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        sig_ready_i = 1'b1;
        bp_mode     = 1'b0;
        hs_flag     = 1'b0;

        // 1: normal four-word dump
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        start_dump(32'h1000_0100, 32'h1000_0110);
        expect_end("t1", 100, 4, 1'b0, 1'b0);

        // 2: backpressure, ready low STALL cycles per word
        do_reset();
        bp_mode = 1'b1;
        push_dump(32'h1000_0100, 32'h1000_0110);
        start_dump(32'h1000_0100, 32'h1000_0110);
        expect_end("t2", 200, 4, 1'b0, 1'b0);
        check("t2_stall_reads", 64'(stall_reads), 64'd0);
        check("t2_stall_cycles", 64'(stall_cycles), 64'(4 * STALL));

        // 3: empty and illegal ranges
        do_reset();
        start_dump(32'h1000_0100, 32'h1000_0100);
        expect_end("t3_empty", 20, 0, 1'b0, 1'b0);
        do_reset();
        start_dump(32'h1000_0104, 32'h1000_0100);
        expect_end("t3_order", 20, 0, 1'b1, 1'b0);
        do_reset();
        start_dump(32'h1000_0102, 32'h1000_0110);
        expect_end("t3_align", 20, 0, 1'b1, 1'b0);
        do_reset();
        start_dump(32'h1000_0000, 32'h1000_1004);
        expect_end("t3_toolong", 20, 0, 1'b1, 1'b0);

        // 3: largest legal signature
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_1100);
        start_dump(32'h1000_0100, 32'h1000_1100);
        expect_end("t3_max", 4000, 1024, 1'b0, 1'b0);

        // 4: timeout with no end flag
        do_reset();
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("t4_pre_timeout", 64'({timeout_o, done_o}), 64'd0);
        @(posedge clk);
        #1;
        check("t4_timeout", 64'({timeout_o, done_o, err_o, busy_o}), 64'b1100);
        bus_write(A_FLAG, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_absorb", 64'({timeout_o, busy_o}), 64'b10);
        check("t4_no_reads", 64'(reads_seen), 64'd0);

        // 4: end flag in the cycle the timeout fires
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        bus_write(A_BEGIN, 32'h1000_0100);
        bus_write(A_END, 32'h1000_0110);
        repeat (TMO - 3) @(posedge clk);
        #1;
        bus_write(A_FLAG, 32'd1);
        expect_end("t4_flag", 100, 4, 1'b0, 1'b0);

        // 5: non-1 end flag ignored, then a real flag starts the dump
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        bus_write(A_BEGIN, 32'h1000_0100);
        bus_write(A_END, 32'h1000_0110);
        bus_write(A_FLAG, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        check("t5_armed", 64'({busy_o, done_o}), 64'd0);
        check("t5_armed_reads", 64'(reads_seen), 64'd0);
        bus_write(A_FLAG, 32'd1);
        expect_end("t5_flag2", 100, 4, 1'b0, 1'b0);

        // 5: begin rewritten after the flag must not affect the dump
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        start_dump(32'h1000_0100, 32'h1000_0110);
        bus_write(A_BEGIN, 32'h1000_0200);
        expect_end("t5_late", 100, 4, 1'b0, 1'b0);

        // 6: reset while the third word is presented, then re-run
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        start_dump(32'h1000_0100, 32'h1000_0110);
        begin
            int n;
            n = 0;
            while (!(words_seen == 2 && sig_valid_o) && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("t6_third_word", 64'({sig_valid_o, 1'b0} | 2'(words_seen == 2)), 64'b11);
        rst = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        do_reset();
        push_dump(32'h1000_0100, 32'h1000_0110);
        start_dump(32'h1000_0100, 32'h1000_0110);
        expect_end("t6_rerun", 100, 4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_compliance_sig_monitor
